// File: rtl/conv_pkg.sv
// Shared definitions for the radix-4 rate-1/2 convolutional encoder:
// FSM state encoding, default code parameters and the parity helper.
// The Viterbi decoder imports the same DEF_K / DEF_G0 / DEF_G1 values.
package conv_pkg;

  localparam int           DEF_K       = 3;
  localparam logic [2:0]   DEF_G0      = 3'b111;
  localparam logic [2:0]   DEF_G1      = 3'b101;
  localparam int           TAIL_DIBITS = (DEF_K - 1) / 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    FLUSH  = 2'd2,
    DONE   = 2'd3
  } enc_state_e;

  // Coded bit = parity of the register window masked by a generator.
  function automatic logic gen_bit(input logic [DEF_K-1:0] r, input logic [DEF_K-1:0] g);
    return ^(r & g);
  endfunction

endpackage

// File: rtl/conv_dibit_step.sv
// Combinational two-bit step of the convolutional encoder.
// Bit[1] of the dibit is shifted in first, then bit[0]; the symbol is
// {c0, c1} of the first bit followed by {c0, c1} of the second.
module conv_dibit_step
  import conv_pkg::*;
#(
  parameter int             K  = DEF_K,
  parameter logic [K-1:0]   G0 = DEF_G0,
  parameter logic [K-1:0]   G1 = DEF_G1
) (
  input  logic [K-2:0] state_i,
  input  logic [1:0]   dibit_i,
  output logic [3:0]   sym_o,
  output logic [K-2:0] state_o
);

  logic [K-1:0] r_hi;
  logic [K-1:0] r_lo;
  logic [K-2:0] s_mid;

  // Two chained single-bit encoder steps, newest bit at the MSB.
  always_comb begin
    r_hi    = {dibit_i[1], state_i};
    s_mid   = {dibit_i[1], state_i[K-2:1]};
    r_lo    = {dibit_i[0], s_mid};
    state_o = {dibit_i[0], s_mid[K-2:1]};
    sym_o   = {gen_bit(r_hi, G0), gen_bit(r_hi, G1),
               gen_bit(r_lo, G0), gen_bit(r_lo, G1)};
  end

endmodule

// File: rtl/conv_encoder.sv
// Framed radix-4 rate-1/2 convolutional encoder with zero-tail flush.
// Handshakes: a transfer happens on a rising edge where valid && ready
// && en are all high; the output slot is one register, so it can be
// refilled in the same cycle that its content is accepted.
// Optional macro ENC_FRAME_CNT_EN adds an 8-bit completed-frame counter.
module conv_encoder
  import conv_pkg::*;
#(
  parameter int           K            = DEF_K,
  parameter logic [K-1:0] G0           = DEF_G0,
  parameter logic [K-1:0] G1           = DEF_G1,
  parameter int           FRAME_DIBITS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_dibit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_sym,
  output logic       out_last,
  output logic       busy,
  output logic       done,
  output logic [1:0] dbg_state
`ifdef ENC_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int TAIL  = (K - 1) / 2;
  localparam int CNT_W = $clog2(FRAME_DIBITS + TAIL + 1);

  enc_state_e       state_q, state_d;
  logic [K-2:0]     s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       sym_q, sym_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic             slot_free;
  logic             accept;
  logic [3:0]       enc_sym, tail_sym;
  logic [K-2:0]     enc_state, tail_state;

  conv_dibit_step #(.K(K), .G0(G0), .G1(G1)) u_step_data (
    .state_i (s_q),
    .dibit_i (in_dibit),
    .sym_o   (enc_sym),
    .state_o (enc_state)
  );

  conv_dibit_step #(.K(K), .G0(G0), .G1(G1)) u_step_tail (
    .state_i (s_q),
    .dibit_i (2'b00),
    .sym_o   (tail_sym),
    .state_o (tail_state)
  );

  assign slot_free = !valid_q || out_ready;
  assign accept    = valid_q && out_ready;

  // State and datapath registers; en=0 freezes everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: frame sequencing, encode/flush steps, slot handling.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    sym_d   = sym_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = done_q;
    if (en) begin
      done_d = 1'b0;
      if (accept) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ENCODE;
            cnt_d   = '0;
          end
        end
        ENCODE: begin
          if (in_valid && slot_free) begin
            sym_d   = enc_sym;
            s_d     = enc_state;
            valid_d = 1'b1;
            last_d  = 1'b0;
            if (cnt_q == CNT_W'(FRAME_DIBITS - 1)) begin
              state_d = FLUSH;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        FLUSH: begin
          if (slot_free) begin
            sym_d   = tail_sym;
            s_d     = tail_state;
            valid_d = 1'b1;
            if (cnt_q == CNT_W'(TAIL - 1)) begin
              last_d  = 1'b1;
              state_d = DONE;
              cnt_d   = '0;
            end else begin
              last_d = 1'b0;
              cnt_d  = cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (accept && last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
            s_d     = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign in_ready  = en && (state_q == ENCODE) && slot_free;
  assign out_valid = valid_q;
  assign out_sym   = sym_q;
  assign out_last  = last_q;
  assign busy      = (state_q == ENCODE) || (state_q == FLUSH);
  assign done      = done_q;
  assign dbg_state = state_q;

`ifdef ENC_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Completed-frame counter, bumped on the edge that raises done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (en && done_d && !done_q) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: randomized frames against a convolution model,
// directed first-symbol, one-dibit-frame, stall, enable and reset cases.
module tb_conv_encoder;

  localparam int         FRAME = 8;
  localparam int         TAIL  = 1;
  localparam logic [2:0] GEN0  = 3'b111;
  localparam logic [2:0] GEN1  = 3'b101;

  // ---------------- clock / reset / DUT signals ----------------
  logic       clk, rst, en, start, in_valid, in_ready, out_valid, out_ready;
  logic       out_last, busy, done;
  logic [1:0] in_dibit, dbg_state;
  logic [3:0] out_sym;
  logic       start1, in_valid1, in_ready1, out_valid1, out_last1, busy1, done1;
  logic       en1, out_ready1;
  logic [1:0] in_dibit1, dbg_state1;
  logic [3:0] out_sym1;
`ifdef ENC_FRAME_CNT_EN
  logic [7:0] frame_cnt, frame_cnt1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  conv_encoder #(.FRAME_DIBITS(FRAME)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_dibit(in_dibit),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym),
    .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef ENC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  conv_encoder #(.FRAME_DIBITS(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .start(start1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_dibit(in_dibit1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_sym(out_sym1),
    .out_last(out_last1), .busy(busy1), .done(done1), .dbg_state(dbg_state1)
`ifdef ENC_FRAME_CNT_EN
    , .frame_cnt(frame_cnt1)
`endif
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [4:0] exp_q[$];     // {last, symbol}
  bit         hist[$];      // input bits of the current frame, oldest first
  bit         done_e = 1'b0;
  int         sym_cnt = 0;
  int         frames_exp = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // c(t) = XOR over taps j of g[K-1-j] * u(t-j), with u before the frame = 0.
  function automatic bit enc_bit(input logic [2:0] g, input int t);
    bit acc = 1'b0;
    for (int j = 0; j < 3; j++)
      if (t - j >= 0 && g[2-j]) acc ^= hist[t-j];
    return acc;
  endfunction

  task automatic model_dibit(input logic [1:0] d, input bit last);
    int t1, t0;
    hist.push_back(d[1]);
    t1 = hist.size() - 1;
    hist.push_back(d[0]);
    t0 = t1 + 1;
    exp_q.push_back({last, enc_bit(GEN0, t1), enc_bit(GEN1, t1),
                     enc_bit(GEN0, t0), enc_bit(GEN1, t0)});
  endtask

  // Output monitor: compares the slot with the queue front every cycle.
  initial begin : monitor
    bit acc, last_acc;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check_eq("done", 32'(done), 32'(done_e));
        if (!en || (out_valid && !out_ready))
          check_eq("in_ready_blocked", 32'(in_ready), 32'd0);
        last_acc = 1'b0;
        acc = out_valid && out_ready && en;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("spurious_valid", 32'd1, 32'd0);
          end else begin
            check_eq("out_sym", 32'(out_sym), 32'(exp_q[0][3:0]));
            check_eq("out_last", 32'(out_last), 32'(exp_q[0][4]));
            if (acc) begin
              last_acc = exp_q[0][4];
              void'(exp_q.pop_front());
              sym_cnt++;
            end
          end
        end
        if (en) done_e = acc && last_acc;
      end
    end
  end

  // ---------------- enable / out_ready drivers ----------------
  int stall_cnt = 0, en_off_cnt = 0;
  bit rand_ready = 1'b0, rand_en = 1'b0;

  initial begin
    en = 1'b1;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (en_off_cnt > 0) begin
        en = 1'b0;
        en_off_cnt--;
      end else begin
        en = rand_en ? ($urandom_range(0, 4) != 0) : 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame();
    int budget = 0;
    hist.delete();
    sym_cnt = 0;
    start = 1'b1;
    forever begin
      @(negedge clk);
      if (en) break;
      budget++;
      if (budget > 200) begin
        check_eq("start_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic send_dibit(input logic [1:0] d, input bit last_data);
    int budget = 0;
    bit ok = 1'b1;
    repeat ($urandom_range(0, 1)) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_dibit = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      budget++;
      if (budget > 200) begin
        check_eq("in_ready_timeout", 32'd0, 32'd1);
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      check_eq("busy_encode", 32'(busy), 32'd1);
      model_dibit(d, 1'b0);
      if (last_data)
        for (int i = 0; i < TAIL; i++) model_dibit(2'b00, i == TAIL - 1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_dibit = 2'($urandom_range(0, 3));
  endtask

  task automatic finish_frame();
    bit got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check_eq("done_seen", 32'(got), 32'd1);
    check_eq("frame_syms", 32'(sym_cnt), 32'(FRAME + TAIL));
    check_eq("exp_empty", 32'(exp_q.size()), 32'd0);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("state_idle", 32'(dbg_state), 32'd0);
    frames_exp++;
`ifdef ENC_FRAME_CNT_EN
    check_eq("frame_cnt", 32'(frame_cnt), 32'(frames_exp % 256));
`endif
    @(posedge clk);
    #1;
  endtask

  // kind: 0 random, 1 all zeros, 2 random with first dibit 2'b10
  task automatic run_frame(input int kind);
    logic [1:0] d;
    start_frame();
    for (int i = 0; i < FRAME; i++) begin
      d = (kind == 1) ? 2'b00 : 2'($urandom_range(0, 3));
      if (kind == 2 && i == 0) d = 2'b10;
      send_dibit(d, i == FRAME - 1);
      if (kind == 2 && i == 0) begin
        check_eq("first_sym_1110", 32'(out_sym), 32'h0000_000e);
        check_eq("first_valid", 32'(out_valid), 32'd1);
      end
    end
    finish_frame();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_out_sym"},   32'(out_sym),   32'd0);
    check_eq({tag, "_out_last"},  32'(out_last),  32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_state"},     32'(dbg_state), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_dibit = 2'b00;
    start1 = 1'b0; in_valid1 = 1'b0; in_dibit1 = 2'b00; en1 = 1'b1; out_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    #2 rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    // One-dibit frame: 2'b11 from state 0, then a single tail symbol.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0; in_valid1 = 1'b1; in_dibit1 = 2'b11;
    check_eq("f1_in_ready", 32'(in_ready1), 32'd1);
    @(posedge clk); #1 in_valid1 = 1'b0;
    check_eq("f1_data_sym", 32'(out_sym1), 32'h0000_000d);
    check_eq("f1_data_valid", 32'(out_valid1), 32'd1);
    check_eq("f1_data_last", 32'(out_last1), 32'd0);
    check_eq("f1_busy", 32'(busy1), 32'd1);
    @(posedge clk); #1;
    check_eq("f1_tail_sym", 32'(out_sym1), 32'h0000_0007);
    check_eq("f1_tail_last", 32'(out_last1), 32'd1);
    check_eq("f1_tail_done", 32'(done1), 32'd0);
    @(posedge clk); #1;
    check_eq("f1_done", 32'(done1), 32'd1);
    check_eq("f1_valid_drop", 32'(out_valid1), 32'd0);
    @(posedge clk); #1;
    check_eq("f1_done_pulse", 32'(done1), 32'd0);

    // Directed frames.
    run_frame(2);
    run_frame(1);
    run_frame(0);

    // Downstream stall for 5 cycles mid-frame.
    fork
      run_frame(0);
      begin
        repeat (4) @(posedge clk);
        #1 stall_cnt = 5;
      end
    join

    // Enable low for 3 cycles mid-frame.
    fork
      run_frame(0);
      begin
        repeat (5) @(posedge clk);
        #1 en_off_cnt = 3;
      end
    join

    // Randomized handshakes and enable.
    rand_ready = 1'b1;
    rand_en = 1'b1;
    repeat (20) run_frame(0);
    rand_ready = 1'b0;
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset mid-frame: partial frame discarded, no done.
    start_frame();
    for (int i = 0; i < 3; i++) send_dibit(2'($urandom_range(0, 3)), 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    hist.delete();
    done_e = 1'b0;
    frames_exp = 0;
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    run_frame(2);

`ifdef ENC_FRAME_CNT_EN
    repeat (255) run_frame(1);
    check_eq("frame_cnt_wrap", 32'(frame_cnt), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
Radix-4 rate-1/2 convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder datapath (extract/branch/add/memory/traceback).
- Accepts one data dibit (2 bits) per transfer.
- Emits one 4-bit coded symbol per dibit.
- Appends zero-tail dibits so every frame ends in state 0, which matches the decoder's traceback start assumption.
- Framed by start/done and valid/ready handshakes.

Parameters:
K, 3, constraint length (memory = K-1 bits; K-1 must be even)
G0, 3'b111, generator polynomial for coded bit c0, MSB applies to newest input bit
G1, 3'b101, generator polynomial for coded bit c1
FRAME_DIBITS, 8, data dibits per frame (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
en  in  1  global enable; 0 freezes all state and blocks both handshakes
start  in  1  one-cycle request to begin a frame; sampled only in IDLE
in_valid  in  1  in_dibit valid
in_ready  out  1  encoder accepts in_dibit this cycle
in_dibit  in  2  data; bit[1] is earlier in time
out_valid  out  1  out_sym valid
out_ready  in  1  downstream accepts out_sym
out_sym  out  4  {c0_t, c1_t, c0_t+1, c1_t+1}
out_last  out  1  marks final tail symbol of frame
busy  out  1  1 in ENCODE or FLUSH
done  out  1  one-cycle pulse after last symbol is accepted

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0, state IDLE, shift register 0, dibit counter 0, output register empty. Takes effect immediately, including mid-frame; the partial frame is discarded with no out_last and no done.
- en=0: no register changes. in_ready=0. Output register holds its value, out_ready is ignored, no transfers occur.
- Shift register s[K-2:0], s[K-2] = newest bit. For each input bit b: r={b,s}; c0=^(r&G0); c1=^(r&G1); s <= {b, s[K-2:1]}. Per dibit, bit[1] is processed first, then bit[0].
- Output slot is a single register: slot_free = !out_valid || out_ready.
- IDLE: in_ready=0, busy=0. start=1 -> ENCODE.
- ENCODE:
  - in_ready = en && slot_free.
  - On transfer (in_valid && in_ready): register the 4-bit symbol, out_valid=1, count++.
  - On the transfer with count==FRAME_DIBITS-1: -> FLUSH, count cleared.
  - start is ignored.
- FLUSH:
  - in_ready=0.
  - Each cycle with en && slot_free, emit the symbol for input dibit 2'b00.
  - Repeat TAIL=(K-1)/2 times; the last one has out_last=1.
  - -> DONE after the last tail symbol is registered.
- DONE:
  - Wait until the out_last symbol is accepted (out_valid && out_ready && en).
  - Pulse done=1 for that cycle's next clock.
  - -> IDLE with s=0.
- Latency: symbol appears on out_sym one clock after the input transfer.
- Throughput: 1 dibit/clock with out_ready held at 1.
- out_valid drops only on acceptance without a same-cycle refill. out_sym and out_last are stable while out_valid && !out_ready.
- Simultaneous acceptance and refill in the same cycle is allowed (no bubble).
- Frame length: FRAME_DIBITS+TAIL symbols; default 9.

Optional Feature:
ENC_FRAME_CNT_EN
- Defined: adds output frame_cnt[7:0]. It resets to 0, increments on each done pulse, and wraps 255->0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - FSM state encoding: IDLE=2'd0, ENCODE=2'd1, FLUSH=2'd2, DONE=2'd3.
  - Default K, G0, G1.
  - Derived TAIL_DIBITS=(K-1)/2.
  - The decoder's FSM imports the same K/G values.
- One sub-module, conv_dibit_step (combinational):
  - Inputs: state and dibit.
  - Outputs: 4-bit symbol and next state.
  - Instantiated in both the ENCODE and FLUSH paths.

Test Plan:
- Reset, start, first dibit 2'b10 with out_ready=1 -> next clock out_sym=4'b1110, out_valid=1.
- From state 0, dibits 2'b11 then FRAME_DIBITS=1 build -> data symbol 4'b1101, tail 4'b0111 with out_last=1, done pulse one clock after acceptance.
- Default frame of eight 2'b00 dibits -> nine symbols of 4'b0000, out_last only on the ninth, busy high from start until DONE.
- out_ready=0 for 5 cycles mid-frame -> in_ready=0 after one stored symbol, out_sym held constant, no dibit lost; resume yields the correct sequence.
- en=0 for 3 cycles mid-frame, and separately rst pulsed mid-frame:
  - en=0 -> all state frozen, frame completes correctly after en returns.
  - rst -> all outputs 0 immediately, no done; the next frame encodes from state 0.
- With ENC_FRAME_CNT_EN: run 256 frames -> frame_cnt wraps to 0.
